// File: rtl/frame_tx_pkg.sv
// Shared types and default framing constants for the frame transmit scheduler.
package frame_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_HDR    = 3'd1,
      ST_FETCH  = 3'd2,
      ST_WAITRD = 3'd3,
      ST_PAY    = 3'd4,
      ST_TRL    = 3'd5,
      ST_FIN    = 3'd6
   } state_t;

   localparam logic [15:0] DEF_HEADER  = 16'h5353;
   localparam logic [15:0] DEF_TRAILER = 16'h4545;

endpackage

// File: rtl/frame_tx_scheduler.sv
// Walks the external sample RAM once per start and streams it to the transmitter as
// HEADER / payload / TRAILER frames over a valid/ready handshake.
module frame_tx_scheduler
   import frame_tx_pkg::*;
#(
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned PAYLOAD_LEN = 58,
   parameter logic [15:0] HEADER      = DEF_HEADER,
   parameter logic [15:0] TRAILER     = DEF_TRAILER
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   input  logic [15:0]       mem_rdata,
   output logic [15:0]       tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] frame_cnt
);

   localparam int unsigned       PC_W      = $clog2(PAYLOAD_LEN + 1);
   localparam logic [PC_W-1:0]   PC_LAST   = PC_W'(PAYLOAD_LEN - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

   state_t          state_reg;
   logic [PC_W-1:0] pc_reg;
   logic            last_sent_reg;
   logic            xfer;

   assign xfer = tx_valid & tx_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         pc_reg        <= '0;
         last_sent_reg <= 1'b0;
         mem_addr      <= '0;
         mem_rd_en     <= 1'b0;
         tx_data       <= '0;
         tx_valid      <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         frame_cnt     <= '0;
      end else if (abort) begin
         // frame_cnt and mem_addr are left as-is so software can see how far the run got
         state_reg <= ST_IDLE;
         mem_rd_en <= 1'b0;
         tx_valid  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  state_reg     <= ST_HDR;
                  mem_addr      <= '0;
                  frame_cnt     <= '0;
                  pc_reg        <= '0;
                  last_sent_reg <= 1'b0;
                  tx_data       <= HEADER;
                  tx_valid      <= 1'b1;
                  busy          <= 1'b1;
               end
            end

            ST_HDR: begin
               if (xfer) begin
                  state_reg <= ST_FETCH;
                  tx_valid  <= 1'b0;
                  mem_rd_en <= 1'b1;
               end
            end

            ST_FETCH: begin
               mem_rd_en <= 1'b0;
               state_reg <= ST_WAITRD;
            end

            // RAM data lands one cycle after the read strobe
            ST_WAITRD: begin
               tx_data   <= mem_rdata;
               tx_valid  <= 1'b1;
               state_reg <= ST_PAY;
            end

            ST_PAY: begin
               if (xfer) begin
                  pc_reg <= pc_reg + 1'b1;
                  if (mem_addr == ADDR_LAST) begin
                     last_sent_reg <= 1'b1;
                     state_reg     <= ST_TRL;
                     tx_data       <= TRAILER;
                  end else begin
                     mem_addr <= mem_addr + 1'b1;
                     if (pc_reg == PC_LAST) begin
                        state_reg <= ST_TRL;
                        tx_data   <= TRAILER;
                     end else begin
                        state_reg <= ST_FETCH;
                        tx_valid  <= 1'b0;
                        mem_rd_en <= 1'b1;
                     end
                  end
               end
            end

            ST_TRL: begin
               if (xfer) begin
                  frame_cnt <= frame_cnt + 1'b1;
                  pc_reg    <= '0;
                  if (last_sent_reg) begin
                     state_reg <= ST_FIN;
                     tx_valid  <= 1'b0;
                     done      <= 1'b1;
                  end else begin
                     state_reg <= ST_HDR;
                     tx_data   <= HEADER;
                  end
               end
            end

            ST_FIN: begin
               done      <= 1'b0;
               busy      <= 1'b0;
               mem_addr  <= '0;
               state_reg <= ST_IDLE;
            end

            default: begin
               state_reg <= ST_IDLE;
               tx_valid  <= 1'b0;
               mem_rd_en <= 1'b0;
               busy      <= 1'b0;
               done      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_frame_tx_scheduler.sv
// Bench for frame_tx_scheduler: two instances (PAYLOAD_LEN 4 and 3) over an 8-word RAM,
// scoreboarded word stream plus abort, reset and handshake-hold sequences.
module tb_frame_tx_scheduler;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        start4 = 1'b0, start3 = 1'b0;
   logic        abort4 = 1'b0, abort3 = 1'b0;
   logic        tx_ready = 1'b0;

   logic [2:0]  mem_addr4, mem_addr3, frame_cnt4, frame_cnt3;
   logic        mem_rd_en4, mem_rd_en3, tx_valid4, tx_valid3;
   logic        busy4, busy3, done4, done3;
   logic [15:0] tx_data4, tx_data3;
   logic [15:0] mem_rdata4 = 16'h0, mem_rdata3 = 16'h0;

   frame_tx_scheduler #(.ADDR_W(3), .PAYLOAD_LEN(4)) u_dut4 (
      .clk(clk), .rst(rst), .start(start4), .abort(abort4),
      .mem_addr(mem_addr4), .mem_rd_en(mem_rd_en4), .mem_rdata(mem_rdata4),
      .tx_data(tx_data4), .tx_valid(tx_valid4), .tx_ready(tx_ready),
      .busy(busy4), .done(done4), .frame_cnt(frame_cnt4)
   );

   frame_tx_scheduler #(.ADDR_W(3), .PAYLOAD_LEN(3)) u_dut3 (
      .clk(clk), .rst(rst), .start(start3), .abort(abort3),
      .mem_addr(mem_addr3), .mem_rd_en(mem_rd_en3), .mem_rdata(mem_rdata3),
      .tx_data(tx_data3), .tx_valid(tx_valid3), .tx_ready(tx_ready),
      .busy(busy3), .done(done3), .frame_cnt(frame_cnt3)
   );

   // RAM models: mem[i] = 16'h1000 + i, one-cycle read latency
   always @(posedge clk) if (mem_rd_en4) mem_rdata4 <= 16'h1000 + {13'd0, mem_addr4};
   always @(posedge clk) if (mem_rd_en3) mem_rdata3 <= 16'h1000 + {13'd0, mem_addr3};

   typedef struct {
      int dut;
      bit rnd;
      bit poke;
      int exp_frames;
      int exp_words;
   } vec_t;

   vec_t        vecs[5];
   logic [15:0] q4[$];
   logic [15:0] q3[$];
   int          words[2];
   int          dones[2];
   logic        prev_v[2];
   logic [15:0] prev_d[2];
   logic        prev_r = 1'b0;
   logic        prev_ab = 1'b0;
   int          n_cmp = 0;
   int          n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic void push_stream(input int d, input int plen);
      int n = 0;
      logic [15:0] w;
      for (int a = 0; a < 8; a++) begin
         if (n == 0) begin
            if (d == 0) q4.push_back(16'h5353); else q3.push_back(16'h5353);
         end
         w = 16'h1000 + 16'(a);
         if (d == 0) q4.push_back(w); else q3.push_back(w);
         n++;
         if (n == plen || a == 7) begin
            if (d == 0) q4.push_back(16'h4545); else q3.push_back(16'h4545);
            n = 0;
         end
      end
   endfunction

   task automatic mon(input int d, input logic v, input logic [15:0] dat, input logic dn);
      logic [15:0] w;
      bit          have = 0;
      if (prev_v[d] && !prev_r && !prev_ab) begin
         chk($sformatf("hold_valid%0d", d), 32'(v), 32'd1);
         chk($sformatf("hold_data%0d", d), 32'(dat), 32'(prev_d[d]));
      end
      if (v && tx_ready) begin
         words[d]++;
         if (d == 0 && q4.size() > 0) begin w = q4.pop_front(); have = 1; end
         if (d == 1 && q3.size() > 0) begin w = q3.pop_front(); have = 1; end
         if (have) begin
            $display("xfer dut%0d word %h expect %h", d, dat, w);
            chk($sformatf("stream%0d", d), 32'(dat), 32'(w));
         end else begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_word%0d: got %h required none", d, dat);
         end
      end
      if (dn) dones[d]++;
      prev_v[d] = v;
      prev_d[d] = dat;
   endtask

   task automatic step();
      @(negedge clk);
      mon(0, tx_valid4, tx_data4, done4);
      mon(1, tx_valid3, tx_data3, done3);
      prev_r  = tx_ready;
      prev_ab = abort4;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input int d);
      if (d == 0) start4 = 1'b1; else start3 = 1'b1;
      step();
      start4 = 1'b0;
      start3 = 1'b0;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int cyc = 0;
      words[v.dut] = 0;
      dones[v.dut] = 0;
      push_stream(v.dut, (v.dut == 0) ? 4 : 3);
      tx_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      pulse_start(v.dut);
      while (dones[v.dut] == 0 && cyc < 2000) begin
         tx_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         start4 = (v.dut == 0) && v.poke && (cyc == 7 || cyc == 20);
         step();
         cyc++;
      end
      start4 = 1'b0;
      tx_ready = 1'b1;
      repeat (3) step();
      chk("done_count", 32'(dones[v.dut]), 32'd1);
      chk("frame_cnt", 32'((v.dut == 0) ? frame_cnt4 : frame_cnt3), 32'(v.exp_frames));
      chk("word_count", 32'(words[v.dut]), 32'(v.exp_words));
      chk("queue_left", 32'((v.dut == 0) ? q4.size() : q3.size()), 32'd0);
      chk("busy_after", 32'((v.dut == 0) ? busy4 : busy3), 32'd0);
      $display("vec %0d: dut=%0d rnd=%0d poke=%0d words=%0d cycles=%0d", idx, v.dut, v.rnd,
               v.poke, words[v.dut], cyc);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_mem_addr"}, 32'(mem_addr4), 32'd0);
      chk({tag, "_mem_rd_en"}, 32'(mem_rd_en4), 32'd0);
      chk({tag, "_tx_data"}, 32'(tx_data4), 32'd0);
      chk({tag, "_tx_valid"}, 32'(tx_valid4), 32'd0);
      chk({tag, "_busy"}, 32'(busy4), 32'd0);
      chk({tag, "_done"}, 32'(done4), 32'd0);
      chk({tag, "_frame_cnt"}, 32'(frame_cnt4), 32'd0);
   endtask

   initial begin
      int cyc;
      vecs[0] = '{0, 1'b0, 1'b0, 2, 12};
      vecs[1] = '{1, 1'b0, 1'b0, 3, 14};
      vecs[2] = '{0, 1'b1, 1'b0, 2, 12};
      vecs[3] = '{0, 1'b0, 1'b1, 2, 12};
      vecs[4] = '{1, 1'b1, 1'b0, 3, 14};
      prev_v = '{1'b0, 1'b0};
      prev_d = '{16'h0, 16'h0};
      words  = '{0, 0};
      dones  = '{0, 0};

      #2;
      chk_reset_outputs("reset");
      @(posedge clk); #1;
      step();
      rst = 1'b0;
      step();

      for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

      // abort during the second payload word of frame 2 (1005)
      dones[0] = 0;
      push_stream(0, 4);
      tx_ready = 1'b1;
      pulse_start(0);
      cyc = 0;
      while (!(tx_valid4 && tx_data4 == 16'h1005) && cyc < 200) begin
         step();
         cyc++;
      end
      chk("abort_reached", 32'(tx_valid4 && tx_data4 == 16'h1005), 32'd1);
      abort4   = 1'b1;
      tx_ready = 1'b0;
      step();
      abort4   = 1'b0;
      chk("abort_tx_valid", 32'(tx_valid4), 32'd0);
      chk("abort_busy", 32'(busy4), 32'd0);
      chk("abort_rd_en", 32'(mem_rd_en4), 32'd0);
      chk("abort_frame_cnt", 32'(frame_cnt4), 32'd1);
      chk("abort_left", 32'(q4.size()), 32'd4);
      q4.delete();
      tx_ready = 1'b1;
      repeat (4) step();
      chk("abort_no_done", 32'(dones[0]), 32'd0);
      chk("abort_idle_valid", 32'(tx_valid4), 32'd0);
      run_vec(5, vecs[0]);

      // abort together with start in IDLE keeps the block idle
      start4 = 1'b1;
      abort4 = 1'b1;
      step();
      start4 = 1'b0;
      abort4 = 1'b0;
      chk("abort_start_busy", 32'(busy4), 32'd0);
      chk("abort_start_valid", 32'(tx_valid4), 32'd0);

      // asynchronous reset while a payload word is on offer
      push_stream(0, 4);
      pulse_start(0);
      cyc = 0;
      while (!(tx_valid4 && tx_data4 == 16'h1002) && cyc < 200) begin
         step();
         cyc++;
      end
      chk("rst_reached", 32'(tx_valid4 && tx_data4 == 16'h1002), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk_reset_outputs("midrst");
      q4.delete();
      q3.delete();
      prev_v = '{1'b0, 1'b0};
      step();
      rst = 1'b0;
      step();
      run_vec(6, vecs[0]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
